// File: rtl/cube_scan_sequencer_pkg.sv
// Shared types and constants for the LED cube scan sequencer.
package cube_pkg;

  localparam int          NUM_LAYERS = 8;
  localparam int          LAYER_W    = 3;
  localparam logic [11:0] WD_LIMIT   = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SHIFT,
    LATCH,
    FIRE,
    WAIT_DONE
  } scan_state_t;

endpackage

// File: rtl/cube_scan_sequencer_if.sv
// Frame-buffer read port and layer-activator handshake of the scan sequencer.
interface cube_scan_sequencer_if #(parameter int COLS = 64);
  import cube_pkg::*;

  logic [LAYER_W-1:0] rd_layer;
  logic               rd_en;
  logic [COLS-1:0]    rd_data;
  logic               act_start;
  logic [LAYER_W-1:0] act_layer;
  logic               act_done;

  modport master (
    output rd_layer, rd_en, act_start, act_layer,
    input  rd_data, act_done
  );

  modport slave (
    input  rd_layer, rd_en, act_start, act_layer,
    output rd_data, act_done
  );

endinterface

// File: rtl/cube_scan_sequencer_column_shifter.sv
// Parallel-load column shift register with SR_HALF clock divider; MSB first,
// data changes only on the falling edge of sr_clk.
module column_shifter #(
  parameter int COLS    = 64,
  parameter int SR_HALF = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [COLS-1:0] data,
  input  logic            start,
  output logic            sr_data,
  output logic            sr_clk,
  output logic            shift_done
);

  localparam int HALF_W = (SR_HALF > 1) ? $clog2(SR_HALF) : 1;
  localparam int BIT_W  = (COLS > 1) ? $clog2(COLS) : 1;

  logic [COLS-1:0]   shreg;
  logic              active;
  logic [HALF_W-1:0] half_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              half_tc;

  assign half_tc    = (half_cnt == '0);
  // Last cycle of the high phase of the last bit: the FSM leaves SHIFT on this edge.
  assign shift_done = active && sr_clk && half_tc && (bit_cnt == '0);
  // Zero fill keeps sr_data low once the column has been sent.
  assign sr_data    = shreg[COLS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      active   <= 1'b0;
      sr_clk   <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load) shreg <= data;
      if (start) begin
        active   <= 1'b1;
        sr_clk   <= 1'b0;
        half_cnt <= HALF_W'(SR_HALF - 1);
        bit_cnt  <= BIT_W'(COLS - 1);
      end else if (active) begin
        if (!half_tc) begin
          half_cnt <= half_cnt - HALF_W'(1);
        end else begin
          half_cnt <= HALF_W'(SR_HALF - 1);
          sr_clk   <= ~sr_clk;
          if (sr_clk) begin
            shreg <= {shreg[COLS-2:0], 1'b0};
            if (bit_cnt == '0) active  <= 1'b0;
            else               bit_cnt <= bit_cnt - BIT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cube_scan_sequencer.sv
// Layer scan sequencer: fetch column pattern, shift it out, latch, fire the
// layer activator. Define SCAN_WATCHDOG_EN to add the act_done watchdog and wd_err.
//
// state     | meaning
// IDLE      | stopped, layer counter at 0
// FETCH     | rd_en strobe for the current layer
// CAPTURE   | rd_data valid, loaded into the column shifter
// SHIFT     | serial column transfer to the driver chain
// LATCH     | sr_latch pulse
// FIRE      | act_start pulse
// WAIT_DONE | waiting for act_done (or watchdog expiry)
module cube_scan_sequencer
  import cube_pkg::*;
#(
  parameter int COLS    = 64,
  parameter int SR_HALF = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  cube_scan_sequencer_if.master        bus,
  output logic                         sr_data,
  output logic                         sr_clk,
  output logic                         sr_latch,
  output logic                         frame_done,
  output logic                         busy
`ifdef SCAN_WATCHDOG_EN
  ,
  output logic                         wd_err
`endif
);

  scan_state_t        state;
  logic [LAYER_W-1:0] layer;
  logic               rd_en_q;
  logic               act_start_q;
  logic               cap_q;
  logic               shift_done;
  logic               layer_done;

`ifdef SCAN_WATCHDOG_EN
  logic [11:0] wd_cnt;
  assign layer_done = bus.act_done || (wd_cnt == '0);
`else
  assign layer_done = bus.act_done;
`endif

  assign bus.rd_layer  = layer;
  assign bus.act_layer = layer;
  assign bus.rd_en     = rd_en_q;
  assign bus.act_start = act_start_q;
  assign busy          = (state != IDLE);

  column_shifter #(
    .COLS    (COLS),
    .SR_HALF (SR_HALF)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (cap_q),
    .data       (bus.rd_data),
    .start      (cap_q),
    .sr_data    (sr_data),
    .sr_clk     (sr_clk),
    .shift_done (shift_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      layer       <= '0;
      rd_en_q     <= 1'b0;
      cap_q       <= 1'b0;
      sr_latch    <= 1'b0;
      act_start_q <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SCAN_WATCHDOG_EN
      wd_cnt      <= '0;
      wd_err      <= 1'b0;
`endif
    end else begin
      rd_en_q     <= 1'b0;
      cap_q       <= 1'b0;
      sr_latch    <= 1'b0;
      act_start_q <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state   <= FETCH;
          rd_en_q <= 1'b1;
        end
        FETCH: begin
          state <= CAPTURE;
          cap_q <= 1'b1;
        end
        CAPTURE: state <= SHIFT;
        SHIFT: if (shift_done) begin
          state    <= LATCH;
          sr_latch <= 1'b1;
        end
        LATCH: begin
          state       <= FIRE;
          act_start_q <= 1'b1;
        end
        FIRE: begin
          // act_done coinciding with FIRE is deliberately not looked at
          state <= WAIT_DONE;
`ifdef SCAN_WATCHDOG_EN
          wd_cnt <= WD_LIMIT - 12'd1;
`endif
        end
        WAIT_DONE: begin
          if (layer_done) begin
            frame_done <= (layer == LAYER_W'(NUM_LAYERS - 1));
            if (enable) begin
              state   <= FETCH;
              rd_en_q <= 1'b1;
              layer   <= layer + LAYER_W'(1);
            end else begin
              state <= IDLE;
              layer <= '0;
            end
`ifdef SCAN_WATCHDOG_EN
            if (!bus.act_done) wd_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 12'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_scan_sequencer.sv
// Randomized self-checking bench for cube_scan_sequencer against a layer-level model.
module tb_cube_scan_sequencer;
  import cube_pkg::*;

  localparam int COLS    = 64;
  localparam int SR_HALF = 1;
  localparam int LAT     = 1 + 1 + 2 * SR_HALF * COLS + 1;
  localparam int WD_CYC  = 4095;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sr_data, sr_clk, sr_latch, frame_done, busy;
`ifdef SCAN_WATCHDOG_EN
  logic wd_err;
`endif

  cube_scan_sequencer_if #(.COLS(COLS)) bus ();

  cube_scan_sequencer #(.COLS(COLS), .SR_HALF(SR_HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .sr_data    (sr_data),
    .sr_clk     (sr_clk),
    .sr_latch   (sr_latch),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef SCAN_WATCHDOG_EN
    ,
    .wd_err     (wd_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Layer-level model state shared by monitor and stimulus
  logic [COLS-1:0] fb [NUM_LAYERS];
  logic [COLS-1:0] got_bits = '0;
  int  exp_layer = 0;
  bit  pend = 0;
  int  pend_layer = 0;
  int  fetch_cyc = 0, fire_cyc = 0;
  int  rise_cnt = 0, latch_cnt = 0;
  bit  prev_clk = 0;
  int  done_delay = 10;
  int  done_at = -1, spur_at = -1, wd_at = -1;
  bit  spur_fire = 0, auto_done = 1, wd_mode = 0;
  bit  frame_next = 0, forbid = 0;
  int  n_fire = 0, n_frame = 0, n_fetch = 0, n_forbid = 0;

  task automatic advance_model();
    if (exp_layer == NUM_LAYERS - 1) frame_next = 1;
    exp_layer = enable ? (exp_layer + 1) % NUM_LAYERS : 0;
  endtask

  always @(negedge clk) begin
    logic exp_frame;
    exp_frame  = frame_next;
    frame_next = 0;
    if (frame_done || exp_frame) check_val("frame_done", frame_done, exp_frame);
    if (frame_done) n_frame++;
    if (forbid && (sr_latch || bus.act_start)) n_forbid++;

    if (pend) begin
      bus.rd_data = fb[pend_layer];
      pend = 0;
    end else begin
      bus.rd_data = {$urandom, $urandom};
    end

    if (bus.rd_en) begin
      check_val("rd_layer", bus.rd_layer, exp_layer);
      pend = 1; pend_layer = bus.rd_layer;
      fetch_cyc = cyc; rise_cnt = 0; latch_cnt = 0; got_bits = '0;
      n_fetch++;
    end
    if (sr_clk && !prev_clk) begin
      got_bits = {got_bits[COLS-2:0], sr_data};
      rise_cnt++;
    end
    prev_clk = sr_clk;
    if (sr_latch) latch_cnt++;

    bus.act_done = 1'b0;
    if (bus.act_start) begin
      n_fire++;
      fire_cyc = cyc;
      check_val("latency", cyc - fetch_cyc, LAT);
      check_val("act_layer", bus.act_layer, exp_layer);
      check_val("columns", got_bits, fb[exp_layer]);
      check_val("sr_clk_rises", rise_cnt, COLS);
      check_val("sr_latch_cnt", latch_cnt, 1);
      if (auto_done) done_at = cyc + done_delay;
      else if (wd_mode) wd_at = cyc + WD_CYC;
      if (spur_fire) begin bus.act_done = 1'b1; spur_fire = 0; end
    end else if (cyc == done_at) begin
      check_val("act_layer_hold", bus.act_layer, exp_layer);
      bus.act_done = 1'b1;
      done_at = -1;
      advance_model();
    end else if (cyc == wd_at) begin
      wd_at = -1;
      advance_model();
    end else if (cyc == spur_at) begin
      bus.act_done = 1'b1;
      spur_at = -1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_rd_en"}, bus.rd_en, 1'b0);
    check_val({tag, "_sr_data"}, sr_data, 1'b0);
    check_val({tag, "_sr_clk"}, sr_clk, 1'b0);
    check_val({tag, "_sr_latch"}, sr_latch, 1'b0);
    check_val({tag, "_act_start"}, bus.act_start, 1'b0);
    check_val({tag, "_frame_done"}, frame_done, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_rd_layer"}, bus.rd_layer, 0);
    check_val({tag, "_act_layer"}, bus.act_layer, 0);
  endtask

  initial begin
    bit spur_shift_done, spur_fire_done;
    int fires0, fetch0;
    for (int i = 0; i < NUM_LAYERS; i++) fb[i] = {$urandom, $urandom};
    fb[0] = 64'h8000_0000_0000_0001;

    rst = 1'b1; enable = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b0; enable = 1'b1;

    // full frame, act_done 10 cycles after act_start, plus two ignored act_done pulses
    spur_shift_done = 0; spur_fire_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (n_frame >= 1) break;
      if (!spur_shift_done && exp_layer == 2 && rise_cnt == 10) begin
        spur_at = cyc; spur_shift_done = 1;
      end
      if (!spur_fire_done && exp_layer == 5) begin
        spur_fire = 1; spur_fire_done = 1;
      end
      tick();
    end
    check_val("frame_cnt", n_frame, 1);
    check_val("frame_fires", n_fire, NUM_LAYERS);
    for (int i = 0; i < 50 && n_fetch < NUM_LAYERS + 1; i++) tick();
    check_val("refetch", n_fetch, NUM_LAYERS + 1);

    // enable dropped during layer 3 SHIFT, random activator delays
    done_delay = $urandom_range(1, 20);
    for (int i = 0; i < 2000; i++) begin
      if (exp_layer == 3 && rise_cnt == 5) break;
      tick();
    end
    enable = 1'b0;
    fires0 = n_fire;
    for (int i = 0; i < 400 && busy; i++) tick();
    check_val("drop_fires", n_fire - fires0, 1);
    repeat (20) tick();
    check_quiet("drop_idle");
    fetch0 = n_fetch;
    enable = 1'b1;
    for (int i = 0; i < 20 && n_fetch == fetch0; i++) tick();
    check_val("reenable_fetch", n_fetch - fetch0, 1);

    // synchronous reset at SHIFT bit 20
    for (int i = 0; i < 400 && rise_cnt != 20; i++) tick();
    check_val("reach_bit20", rise_cnt, 20);
    rst = 1'b1; enable = 1'b0; forbid = 1;
    tick();
    done_at = -1; exp_layer = 0; pend = 0;
    check_quiet("rst_shift");
    rst = 1'b0;
    repeat (300) tick();
    check_val("no_latch_fire", n_forbid, 0);
    check_val("rst_busy", busy, 1'b0);
    forbid = 0;

    // fresh random frame contents, one more layer from layer 0
    for (int i = 0; i < NUM_LAYERS; i++) fb[i] = {$urandom, $urandom};
    done_delay = $urandom_range(1, 20);
    fires0 = n_fire;
    enable = 1'b1;
    for (int i = 0; i < 400 && n_fire == fires0; i++) tick();
    enable = 1'b0;
    check_val("restart_fire", n_fire - fires0, 1);
    for (int i = 0; i < 400 && busy; i++) tick();
    check_val("restart_idle", busy, 1'b0);

`ifdef SCAN_WATCHDOG_EN
    auto_done = 0; wd_mode = 1;
    fires0 = n_fire;
    enable = 1'b1;
    for (int i = 0; i < 400 && n_fire == fires0; i++) tick();
    check_val("wd_err_pre", wd_err, 1'b0);
    fetch0 = n_fetch;
    for (int i = 0; i < 5000 && n_fetch == fetch0; i++) tick();
    check_val("wd_advance", fetch_cyc - fire_cyc, WD_CYC + 1);
    check_val("wd_err_set", wd_err, 1'b1);
    auto_done = 1; wd_mode = 0; enable = 1'b0;
    for (int i = 0; i < 400 && busy; i++) tick();
    check_val("wd_err_hold", wd_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("wd_err_clear", wd_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
